// File: rtl/serial_adder.sv
// Bit-serial adder: accepts an operand pair, adds it LSB first at one bit per
// cycle, then presents {carry, sum} until the downstream side takes it.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high. in_ready is high only in IDLE. out_valid is high only in DONE.
// out_ready is ignored in IDLE and SHIFT. Every output comes from a register
// or the FSM state, so no input reaches an output combinationally.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             carry,
    output logic             busy,
    output logic [1:0]       dbg_state
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    localparam int            CW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             c_q, c_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;

    logic             sum_bit;
    logic             c_next;
    logic [WIDTH-1:0] res_shifted;

    // One full-adder slice on the current LSBs plus the running carry.
    assign sum_bit     = a_sh_q[0] ^ b_sh_q[0] ^ c_q;
    assign c_next      = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & c_q) | (b_sh_q[0] & c_q);
    assign res_shifted = {sum_bit, res_q[WIDTH-1:1]};

    // State and datapath registers; reset clears everything and aborts any addition.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            a_sh_q  <= '0;
            b_sh_q  <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            c_q     <= 1'b0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_sh_q  <= a_sh_d;
            b_sh_q  <= b_sh_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            c_q     <= c_d;
            carry_q <= carry_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and datapath update; every register holds unless its state says otherwise.
    always_comb begin
        state_d = state_q;
        a_sh_d  = a_sh_q;
        b_sh_d  = b_sh_q;
        res_d   = res_q;
        sum_d   = sum_q;
        c_d     = c_q;
        carry_d = carry_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                // Operands are only sampled here, on the accepting edge.
                if (in_valid) begin
                    a_sh_d  = a;
                    b_sh_d  = b;
                    res_d   = '0;
                    c_d     = 1'b0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                a_sh_d = a_sh_q >> 1;
                b_sh_d = b_sh_q >> 1;
                res_d  = res_shifted;
                c_d    = c_next;
                cnt_d  = cnt_q + CNT_ONE;
                if (cnt_q == LAST_BIT) begin
                    // Publish the finished result; it stays put until the next one lands.
                    sum_d   = res_shifted;
                    carry_d = c_next;
                    cnt_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = (state_q == DONE);
    assign sum       = sum_q;
    assign carry     = carry_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_serial_adder.sv
// Bench for serial_adder (WIDTH=8): directed cases, reset abort, backpressure,
// randomized single operations and a back-to-back run with operand churn.
// Inputs change at posedge+1; the monitor samples at negedge.
module tb_serial_adder;

    localparam int W = 8;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry;
    logic         busy;
    logic [1:0]   dbg_state;

    int           total;
    int           bad;
    int           cyc;
    int           acc_cnt;
    int           last_acc;
    bit           b2b_mode;
    logic [W:0]   exp_q[$];

    serial_adder #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .carry     (carry),
        .busy      (busy),
        .dbg_state (dbg_state)
    );

    // Clock and cycle counter
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        if (obs !== exp_v) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp_v, $time);
        end
    endtask

    // Reference model: plain integer addition, carry is the extra top bit
    function automatic logic [W:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y);
        return {1'b0, x} + {1'b0, y};
    endfunction

    // Monitor / scoreboard: record acceptances, compare delivered results
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) begin
                exp_q.push_back(ref_add(a, b));
                if (b2b_mode && acc_cnt > 0)
                    check("b2b_spacing", 32'(cyc - last_acc), 32'(W + 2));
                acc_cnt++;
                last_acc = cyc;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("mon_unexpected_result", 32'(out_valid), 32'd0);
                end else begin
                    logic [W:0] e;
                    e = exp_q.pop_front();
                    check("mon_result", 32'({carry, sum}), 32'(e));
                end
            end
        end
    end

    // Wait (bounded) for out_valid; n = rising edges since the accepting edge
    task automatic wait_result(output int n);
        n = 0;
        while (!out_valid && n < 40) begin
            @(posedge clk); #1;
            a = W'($urandom);
            b = W'($urandom);
            n++;
        end
    endtask

    // Driver: one transaction with optional output backpressure
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv,
                          input logic [W:0] exp_v, input int stall, input string tag);
        int n;
        @(posedge clk); #1;
        check({tag, "_idle_ready"}, 32'(in_ready), 32'd1);
        a = av;
        b = bv;
        in_valid = 1'b1;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a = W'($urandom);
        b = W'($urandom);
        wait_result(n);
        check({tag, "_latency"}, 32'(n), 32'(W));
        check({tag, "_sum"}, 32'(sum), 32'(exp_v[W-1:0]));
        check({tag, "_carry"}, 32'(carry), 32'(exp_v[W]));
        check({tag, "_busy"}, 32'(busy), 32'd1);
        for (int i = 0; i < stall; i++) begin
            @(posedge clk); #1;
            check({tag, "_hold_valid"}, 32'(out_valid), 32'd1);
            check({tag, "_hold_sum"}, 32'({carry, sum}), 32'(exp_v));
            check({tag, "_hold_in_ready"}, 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_after_sum"}, 32'({carry, sum}), 32'(exp_v));
        check({tag, "_after_ready"}, 32'(in_ready), 32'd1);
    endtask

    // Reset abort mid-SHIFT, then accept on the first edge after release
    task automatic reset_abort;
        int n;
        @(posedge clk); #1;
        a = 8'h12;
        b = 8'h34;
        in_valid = 1'b1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_busy", 32'(busy), 32'd0);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_sum", 32'({carry, sum}), 32'd0);
        check("abort_in_ready", 32'(in_ready), 32'd1);
        exp_q.delete();
        a = 8'h01;
        b = 8'h02;
        in_valid = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("post_rst_accept", 32'(busy), 32'd1);
        wait_result(n);
        check("post_rst_latency", 32'(n), 32'(W));
        check("post_rst_result", 32'({carry, sum}), 32'h003);
        @(posedge clk); #1;
        check("post_rst_valid_drop", 32'(out_valid), 32'd0);
    endtask

    // Back-to-back: in_valid held high, a/b churn every cycle
    task automatic back_to_back;
        int n;
        @(posedge clk); #1;
        b2b_mode = 1'b1;
        acc_cnt = 0;
        out_ready = 1'b1;
        in_valid = 1'b1;
        a = W'($urandom);
        b = W'($urandom);
        n = 0;
        while (acc_cnt < 4 && n < 200) begin
            @(posedge clk); #1;
            a = W'($urandom);
            b = W'($urandom);
            n++;
        end
        in_valid = 1'b0;
        check("b2b_accept_count", 32'(acc_cnt), 32'd4);
        n = 0;
        while ((exp_q.size() > 0 || busy) && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        check("b2b_drained", 32'(exp_q.size()), 32'd0);
        b2b_mode = 1'b0;
    endtask

    // Main sequence
    initial begin
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        total = 0;
        bad = 0;
        cyc = 0;
        acc_cnt = 0;
        last_acc = 0;
        b2b_mode = 1'b0;
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        a = '0;
        b = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_sum", 32'(sum), 32'd0);
        check("reset_carry", 32'(carry), 32'd0);
        check("reset_in_ready", 32'(in_ready), 32'd1);
        check("reset_busy", 32'(busy), 32'd0);

        run_op(8'h5A, 8'h3C, 9'h096, 0, "add_5a_3c");
        run_op(8'h00, 8'h00, 9'h000, 0, "add_zero");
        run_op(8'hFF, 8'h01, 9'h100, 0, "ovf_ff_01");
        run_op(8'hFF, 8'hFF, 9'h1FE, 0, "ovf_ff_ff");
        run_op(8'h80, 8'h80, 9'h100, 5, "bp_80_80");

        reset_abort();

        for (int i = 0; i < 6; i++) begin
            ra = W'($urandom);
            rb = W'($urandom);
            run_op(ra, rb, ref_add(ra, rb), $urandom_range(0, 3), "rand");
        end

        back_to_back();

        check("final_queue_empty", 32'(exp_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
